// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Purpose  : Opcodes, FSM state encoding, fixed RF operand addresses and
//            state-class helpers for the UART command controller.
// Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    OPA      = 4'd5,
    OPB      = 4'd6,
    ALU_FN   = 4'd7,
    ALU_WAIT = 4'd8,
    TX_LO    = 4'd9,
    TX_HI    = 4'd10,
    TX_RD    = 4'd11
  } state_e;

  // States that still expect command bytes from the host
  function automatic logic is_collecting(state_e s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR) ||
           (s == OPA) || (s == OPB) || (s == ALU_FN);
  endfunction

  // States waiting for a result or draining one; new bytes are overruns
  function automatic logic is_busy(state_e s);
    return (s == RD_WAIT) || (s == ALU_WAIT) || (s == TX_LO) ||
           (s == TX_HI) || (s == TX_RD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_timeout.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_timeout
// Purpose  : Inter-byte timeout counter. Clears on every accepted byte or
//            whenever the FSM is not collecting a command; flags expiry once
//            TIMEOUT_CYCLES-1 is reached. Only built under CMD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned c_CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT_CYCLES - 1);

  logic [c_CW-1:0] r_cnt;

  assign o_expired = i_run && (r_cnt == c_LAST);

  // Count idle cycles while a command is partially received
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || !i_run) begin
      r_cnt <= '0;
    end else if (r_cnt != c_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl
// Purpose  : Parses UART RX byte frames into register-file write/read and ALU
//            commands, drives RF/ALU/clock-gate strobes and returns results
//            to the TX FIFO. Optional inter-byte timeout: define
//            CMD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  PAR_ERR,
  input  logic                  FRM_ERR,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  input  logic                  RF_RdData_VLD,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  output logic                  CLK_GATE_EN,
  input  logic [15:0]           ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  output logic [7:0]            TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  FIFO_FULL,
  output logic                  CMD_ERR
);

  state_e      r_state;
  logic [15:0] r_alu_res;

  logic w_acc;
  logic w_err;
  logic w_timeout;
  logic w_tx_state;

  assign w_acc      = RX_D_VLD && !PAR_ERR && !FRM_ERR;
  assign w_err      = RX_D_VLD && (PAR_ERR || FRM_ERR);
  assign w_tx_state = (r_state == TX_LO) || (r_state == TX_HI) || (r_state == TX_RD);

  // The push is decoded from the state and the live FIFO_FULL so that a push
  // never lands on a full FIFO and can happen the very cycle space appears.
  assign TX_D_VLD = w_tx_state && !FIFO_FULL;

`ifdef CMD_TIMEOUT_EN
  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (CLK),
    .i_rst_n   (RST),
    .i_clear   (w_acc),
    .i_run     (is_collecting(r_state)),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // Command FSM with registered strobes, address/data/function and result
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_alu_res   <= '0;
      RF_WrEn     <= 1'b0;
      RF_RdEn     <= 1'b0;
      RF_Address  <= '0;
      RF_WrData   <= '0;
      ALU_FUN     <= '0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      CMD_ERR     <= 1'b0;
    end else begin
      RF_WrEn <= 1'b0;
      RF_RdEn <= 1'b0;
      CMD_ERR <= 1'b0;
      if (w_err) begin
        // Corrupted byte: abandon whatever was in progress
        CMD_ERR     <= 1'b1;
        ALU_EN      <= 1'b0;
        CLK_GATE_EN <= 1'b0;
        r_state     <= IDLE;
      end else if (w_timeout && !w_acc) begin
        CMD_ERR <= 1'b1;
        r_state <= IDLE;
      end else begin
        // A byte arriving while a result is pending or draining is dropped
        if (w_acc && is_busy(r_state)) begin
          CMD_ERR <= 1'b1;
        end
        case (r_state)
          IDLE: begin
            if (w_acc) begin
              case (RX_P_DATA)
                CMD_RF_WR:   r_state <= WR_ADDR;
                CMD_RF_RD:   r_state <= RD_ADDR;
                CMD_ALU_OP:  r_state <= OPA;
                CMD_ALU_NOP: r_state <= ALU_FN;
                default:     r_state <= IDLE;
              endcase
            end
          end
          WR_ADDR: begin
            if (w_acc) begin
              RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
              r_state    <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (w_acc) begin
              RF_WrData <= RX_P_DATA;
              RF_WrEn   <= 1'b1;
              r_state   <= IDLE;
            end
          end
          RD_ADDR: begin
            if (w_acc) begin
              RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
              RF_RdEn    <= 1'b1;
              r_state    <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (RF_RdData_VLD) begin
              TX_P_DATA <= RF_RdData;
              r_state   <= TX_RD;
            end
          end
          OPA: begin
            if (w_acc) begin
              RF_Address <= ADDR_WIDTH'(OPA_ADDR);
              RF_WrData  <= RX_P_DATA;
              RF_WrEn    <= 1'b1;
              r_state    <= OPB;
            end
          end
          OPB: begin
            if (w_acc) begin
              RF_Address <= ADDR_WIDTH'(OPB_ADDR);
              RF_WrData  <= RX_P_DATA;
              RF_WrEn    <= 1'b1;
              r_state    <= ALU_FN;
            end
          end
          ALU_FN: begin
            if (w_acc) begin
              ALU_FUN     <= RX_P_DATA[3:0];
              ALU_EN      <= 1'b1;
              CLK_GATE_EN <= 1'b1;
              r_state     <= ALU_WAIT;
            end
          end
          ALU_WAIT: begin
            if (ALU_OUT_VLD) begin
              r_alu_res   <= ALU_OUT;
              TX_P_DATA   <= ALU_OUT[7:0];
              ALU_EN      <= 1'b0;
              CLK_GATE_EN <= 1'b0;
              r_state     <= TX_LO;
            end
          end
          TX_LO: begin
            if (!FIFO_FULL) begin
              TX_P_DATA <= r_alu_res[15:8];
              r_state   <= TX_HI;
            end
          end
          TX_HI, TX_RD: begin
            if (!FIFO_FULL) begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_ctrl
// Purpose  : Scoreboard bench for uart_cmd_ctrl. Stimulus pushes expected RF
//            writes, RF reads, TX bytes and CMD_ERR pulses; a monitor pops and
//            compares whenever the DUT strobes one of them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic        PAR_ERR = 1'b0;
  logic        FRM_ERR = 1'b0;
  logic        RF_WrEn;
  logic        RF_RdEn;
  logic [3:0]  RF_Address;
  logic [7:0]  RF_WrData;
  logic [7:0]  RF_RdData = '0;
  logic        RF_RdData_VLD = 1'b0;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic        CLK_GATE_EN;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        FIFO_FULL = 1'b0;
  logic        CMD_ERR;

  uart_cmd_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(4096)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .PAR_ERR(PAR_ERR), .FRM_ERR(FRM_ERR),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL),
    .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  exp_tx[$];
  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  int          pending_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic pe = 1'b0, input logic fe = 1'b0);
    @(posedge CLK); #1;
    RX_P_DATA = b; RX_D_VLD = 1'b1; PAR_ERR = pe; FRM_ERR = fe;
    @(posedge CLK); #1;
    RX_D_VLD = 1'b0; PAR_ERR = 1'b0; FRM_ERR = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: every DUT strobe must match the head of its expectation queue
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (TX_D_VLD) begin
          chk("tx_while_full", FIFO_FULL, 0);
          chk("tx_expected", exp_tx.size() > 0, 1);
          if (exp_tx.size() > 0) chk("tx_byte", TX_P_DATA, exp_tx.pop_front());
        end
        if (RF_WrEn) begin
          chk("wr_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) chk("wr_addr_data", {RF_Address, RF_WrData}, exp_wr.pop_front());
        end
        if (RF_RdEn) begin
          chk("rd_expected", exp_rd.size() > 0, 1);
          if (exp_rd.size() > 0) chk("rd_addr", RF_Address, exp_rd.pop_front());
        end
        if (CMD_ERR) begin
          chk("cmd_err_expected", pending_err > 0, 1);
          if (pending_err > 0) pending_err--;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(3);
    chk("rst_wren", RF_WrEn, 0);
    chk("rst_addr", RF_Address, 0);
    chk("rst_txvld", TX_D_VLD, 0);
    chk("rst_aluen", ALU_EN, 0);
    RST = 1'b1;
    idle(2);
    chk("post_rst_outputs",
        {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}, 0);

    // Write 0x3C to address 5
    exp_wr.push_back({4'h5, 8'h3C});
    send(8'hAA); send(8'h05); send(8'h3C);
    idle(3);

    // Read address 2, data returned three cycles later
    exp_rd.push_back(4'h2);
    send(8'hBB); send(8'h02);
    idle(2);
    exp_tx.push_back(8'h7E);
    RF_RdData = 8'h7E; RF_RdData_VLD = 1'b1;
    @(posedge CLK); #1; RF_RdData_VLD = 1'b0;
    @(negedge CLK);
    chk("rd_latency", TX_D_VLD, 1);
    idle(3);

    // ALU with operands
    exp_wr.push_back({4'h0, 8'h10});
    exp_wr.push_back({4'h1, 8'h20});
    send(8'hCC); send(8'h10); send(8'h20); send(8'h00);
    chk("alu_en_on", ALU_EN, 1);
    chk("clk_gate_on", CLK_GATE_EN, 1);
    chk("alu_fun0", ALU_FUN, 0);
    idle(2);
    chk("alu_en_hold", ALU_EN, 1);
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12);
    ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
    @(posedge CLK); #1; ALU_OUT_VLD = 1'b0;
    chk("alu_en_drop", ALU_EN, 0);
    @(negedge CLK);
    chk("alu_latency", TX_D_VLD, 1);
    chk("alu_lo", TX_P_DATA, 8'h34);
    @(negedge CLK);
    chk("alu_b2b", TX_D_VLD, 1);
    chk("alu_hi", TX_P_DATA, 8'h12);
    idle(3);

    // FIFO back-pressure during TX_LO
    FIFO_FULL = 1'b1;
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12);
    send(8'hDD); send(8'h03);
    chk("alu_fun3", ALU_FUN, 3);
    ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
    @(posedge CLK); #1; ALU_OUT_VLD = 1'b0;
    idle(9);
    chk("bp_hold", TX_P_DATA, 8'h34);
    FIFO_FULL = 1'b0;
    @(negedge CLK);
    chk("bp_push", TX_D_VLD, 1);
    chk("bp_data", TX_P_DATA, 8'h34);
    idle(3);

    // Parity error mid-write aborts, junk opcode ignored, FSM still in IDLE
    pending_err++;
    send(8'hAA); send(8'h05); send(8'h3C, 1'b1, 1'b0);
    idle(3);
    send(8'h55);
    idle(3);
    exp_wr.push_back({4'h7, 8'h42});
    send(8'hAA); send(8'h07); send(8'h42);
    idle(2);

    // Framing error in IDLE
    pending_err++;
    send(8'hBB, 1'b0, 1'b1);
    idle(2);

    // Overrun in RD_WAIT: byte dropped, read still completes
    exp_rd.push_back(4'h3);
    send(8'hBB); send(8'h03);
    pending_err++;
    send(8'h11);
    exp_tx.push_back(8'h99);
    RF_RdData = 8'h99; RF_RdData_VLD = 1'b1;
    @(posedge CLK); #1; RF_RdData_VLD = 1'b0;
    idle(3);

    // Asynchronous reset in ALU_WAIT
    send(8'hDD); send(8'h01);
    idle(2);
    chk("alu_wait_en", ALU_EN, 1);
    #3 RST = 1'b0;
    #1;
    chk("midrst_outputs",
        {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}, 0);
    idle(2);
    @(negedge CLK); RST = 1'b1;
    idle(2);

`ifdef CMD_TIMEOUT_EN
    // Partial read command times out, next command runs normally
    pending_err++;
    send(8'hBB);
    idle(4100);
    chk("timeout_err_seen", pending_err, 0);
    exp_wr.push_back({4'h1, 8'h02});
    send(8'hAA); send(8'h01); send(8'h02);
    idle(3);
`endif

    chk("tx_q_empty", exp_tx.size(), 0);
    chk("wr_q_empty", exp_wr.size(), 0);
    chk("rd_q_empty", exp_rd.size(), 0);
    chk("err_pending", pending_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command sequencer between the UART receiver and the system datapath. It parses byte frames delivered by the UART RX (P_DATA/data_valid/parity_error/framing_error) into register-file write, register-file read and ALU commands. It drives the register file, ALU and ALU clock gate, and returns results as bytes to the UART TX FIFO.

## Interface
- DATA_WIDTH, 8, UART byte and register-file data width
- ADDR_WIDTH, 4, register-file address width; the low ADDR_WIDTH bits of the address byte are used, upper bits ignored
- TIMEOUT_CYCLES, 4096, inter-byte timeout in CLK cycles (used only with CMD_TIMEOUT_EN)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- RX_P_DATA  in  8  received byte
- RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA valid
- PAR_ERR  in  1  parity error, qualified by RX_D_VLD
- FRM_ERR  in  1  framing error, qualified by RX_D_VLD
- RF_WrEn  out  1  register-file write strobe
- RF_RdEn  out  1  register-file read strobe
- RF_Address  out  ADDR_WIDTH  register-file address
- RF_WrData  out  DATA_WIDTH  register-file write data
- RF_RdData  in  DATA_WIDTH  read data
- RF_RdData_VLD  in  1  read data valid pulse
- ALU_FUN  out  4  ALU function select
- ALU_EN  out  1  ALU enable
- CLK_GATE_EN  out  1  ALU clock-gate enable
- ALU_OUT  in  16  ALU result
- ALU_OUT_VLD  in  1  result valid pulse
- TX_P_DATA  out  8  byte to the TX FIFO
- TX_D_VLD  out  1  one-cycle FIFO push
- FIFO_FULL  in  1  TX FIFO full
- CMD_ERR  out  1  one-cycle error pulse

## Operation
- **Byte acceptance:** a byte is accepted when RX_D_VLD=1 and PAR_ERR=0 and FRM_ERR=0.
- **Errored byte:** RX_D_VLD=1 with either error flag set causes a CMD_ERR pulse and an abort to IDLE. No RF or ALU strobe is issued.
- **Opcodes (in IDLE):**
  - 0xAA: write; next bytes are address, then data.
  - 0xBB: read; next byte is address.
  - 0xCC: ALU with operands; next bytes are A, B, then FUN.
  - 0xDD: ALU without operands; next byte is FUN.
  - Any other byte: ignored, no CMD_ERR.
- **States:** IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, ALU_FN, ALU_WAIT, TX_LO, TX_HI, TX_RD.
- **Transitions:**
  - Write: IDLE -0xAA-> WR_ADDR -addr-> WR_DATA -data-> IDLE, with RF_WrEn pulsed.
  - Read: IDLE -0xBB-> RD_ADDR -addr-> RD_WAIT -RF_RdData_VLD-> TX_RD -push-> IDLE.
  - ALU with operands: IDLE -0xCC-> OPA, which writes A to RF address 0 -> OPB, which writes B to RF address 1 -> ALU_FN.
  - ALU without operands: IDLE -0xDD-> ALU_FN.
  - ALU completion: ALU_FN -fun-> ALU_WAIT -ALU_OUT_VLD-> TX_LO -push-> TX_HI -push-> IDLE.
- **ALU result capture:** ALU_OUT is captured into a 16-bit register on ALU_OUT_VLD. It is sent low byte first, then high byte.
- **Overrun:** an accepted byte arriving in RD_WAIT, ALU_WAIT, TX_LO, TX_HI or TX_RD is dropped and CMD_ERR is pulsed. The state is unchanged.
- **Output registers:** RF_Address, RF_WrData and ALU_FUN are registers that hold their last value between commands.

## Timing
- **Reset:** all outputs are 0 and the state is IDLE. Assertion mid-command aborts immediately, with no pending strobe.
- **RF_WrEn:** a one-cycle pulse in the cycle after the data/A/B byte's RX_D_VLD. RF_Address and RF_WrData are stable in that cycle.
- **RF_RdEn:** a one-cycle pulse in the cycle after the address byte's RX_D_VLD. It is not re-issued while in RD_WAIT.
- **ALU_EN and CLK_GATE_EN:**
  - Both assert in the cycle after the FUN byte's RX_D_VLD.
  - ALU_EN holds until the cycle ALU_OUT_VLD is seen and drops the next cycle.
  - CLK_GATE_EN is high throughout ALU_FN→ALU_WAIT.
- **TX push:** TX_D_VLD is a one-cycle pulse, issued only in a cycle with FIFO_FULL=0. While FIFO_FULL=1 the controller stalls in its TX state, holding TX_P_DATA.
- **Back-to-back pushes:** TX_LO and TX_HI pushes may be on consecutive cycles.
- **Simultaneous events:** RF_RdData_VLD or ALU_OUT_VLD arriving together with an accepted RX byte takes the result and drops the byte, pulsing CMD_ERR.
- **Minimum latency:**
  - Read: RF_RdData_VLD to TX_D_VLD is 1 cycle.
  - ALU: ALU_OUT_VLD to the first TX_D_VLD is 1 cycle.

## Configuration
- **Macro CMD_TIMEOUT_EN.**
- **Defined:** a counter clears on every accepted byte and counts while in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB or ALU_FN.
  - Reaching TIMEOUT_CYCLES-1 returns the FSM to IDLE with a CMD_ERR pulse.
  - The counter does not run in wait or TX states.
- **Undefined:** no counter is built; a partial command waits indefinitely.

## Structure
- **Package uart_cmd_pkg:**
  - opcode constants CMD_RF_WR=0xAA, CMD_RF_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD;
  - the state enum;
  - RF addresses OPA_ADDR=0 and OPB_ADDR=1.
- **Sub-module uart_cmd_timeout:** the timeout counter, instantiated only under CMD_TIMEOUT_EN. The FSM, output registers and result register live in uart_cmd_ctrl.

## Test plan
- **Write:** bytes 0xAA,0x05,0x3C → one RF_WrEn pulse with RF_Address=5, RF_WrData=0x3C; no TX_D_VLD.
- **Read:** bytes 0xBB,0x02; RF_RdData=0x7E with RF_RdData_VLD 3 cycles later → one TX_D_VLD with TX_P_DATA=0x7E; FSM back in IDLE.
- **ALU with operands:** bytes 0xCC,0x10,0x20,0x00; ALU_OUT=0x1234 → RF writes (0,0x10) then (1,0x20); ALU_FUN=0; TX bytes 0x34 then 0x12.
- **FIFO back-pressure:** FIFO_FULL=1 for 10 cycles during TX_LO → no push while full; 0x34 is pushed in the first cycle after FIFO_FULL falls, then 0x12.
- **Errors:**
  - 0xAA,0x05 followed by a byte with PAR_ERR=1 → CMD_ERR pulse, no RF_WrEn, IDLE.
  - 0x55 in IDLE is ignored.
- **Reset and timeout:**
  - Reset asserted in ALU_WAIT → all outputs 0 immediately.
  - With CMD_TIMEOUT_EN, 0xBB followed by silence → CMD_ERR at TIMEOUT_CYCLES, then 0xAA,0x01,0x02 executes normally.
